bus_mux_hold: RTL and testbench

- Parametrised successor to the CPU datapath bus multiplexer: NUM_SRC sources of WIDTH bits, driven by one-hot out-enables.
- Adds bus-hold: when no source drives, the bus keeps its last driven value instead of floating or latching.
- Adds multi-drive conflict detection, a sticky error flag and a registered record of the last driver index.
- Sits between register file / special registers (HI, LO, Z, PC, MDR, InPort, C) and all datapath consumers.

---
 rtl/cpu_bus_pkg.sv | 36 +++
 rtl/bus_mux_hold_if.sv | 53 +++++
 rtl/bus_prio_enc.sv | 30 +++
 rtl/bus_mux_hold.sv | 89 ++++++++
 tb/tb_bus_mux_hold.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU datapath bus: source indices, default
// geometry and the bus word type.
package cpu_bus_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NUM_SRC = 24;

   // Source indices: general registers first, then special registers.
   localparam int SRC_R0     = 0;
   localparam int SRC_R1     = 1;
   localparam int SRC_R2     = 2;
   localparam int SRC_R3     = 3;
   localparam int SRC_R4     = 4;
   localparam int SRC_R5     = 5;
   localparam int SRC_R6     = 6;
   localparam int SRC_R7     = 7;
   localparam int SRC_R8     = 8;
   localparam int SRC_R9     = 9;
   localparam int SRC_R10    = 10;
   localparam int SRC_R11    = 11;
   localparam int SRC_R12    = 12;
   localparam int SRC_R13    = 13;
   localparam int SRC_R14    = 14;
   localparam int SRC_R15    = 15;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHIGH  = 18;
   localparam int SRC_ZLOW   = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_C      = 23;

   typedef logic [DEF_WIDTH-1:0] bus_word_t;

endpackage

// File: rtl/bus_mux_hold_if.sv
// Bus interface between the datapath sources and the bus mux.
// Optional macro BUS_CONFLICT_CNT_EN adds the conflict_cnt signal.
//
// There is no valid/ready handshake here: each src_out bit is a plain
// per-cycle out-enable, sampled combinationally, expected one-hot or zero.
// bus_active marks a cycle in which some source drives; outputs carry no
// back-pressure.
interface bus_mux_hold_if
   import cpu_bus_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int IDX_W   = $clog2(NUM_SRC)
`ifdef BUS_CONFLICT_CNT_EN
   ,
   parameter int CNT_W   = 8
`endif
);

   logic [NUM_SRC*WIDTH-1:0] src_data;
   logic [NUM_SRC-1:0]       src_out;
   logic                     clr_err;
   logic [WIDTH-1:0]         bus_out;
   logic                     bus_active;
   logic [IDX_W-1:0]         bus_sel;
   logic                     conflict;
   logic                     conflict_sticky;
   logic [IDX_W-1:0]         last_src;
`ifdef BUS_CONFLICT_CNT_EN
   logic [CNT_W-1:0]         conflict_cnt;
`endif

`ifdef BUS_CONFLICT_CNT_EN
   modport master (
      output src_data, src_out, clr_err,
      input  bus_out, bus_active, bus_sel, conflict, conflict_sticky, last_src, conflict_cnt
   );
   modport slave (
      input  src_data, src_out, clr_err,
      output bus_out, bus_active, bus_sel, conflict, conflict_sticky, last_src, conflict_cnt
   );
`else
   modport master (
      output src_data, src_out, clr_err,
      input  bus_out, bus_active, bus_sel, conflict, conflict_sticky, last_src
   );
   modport slave (
      input  src_data, src_out, clr_err,
      output bus_out, bus_active, bus_sel, conflict, conflict_sticky, last_src
   );
`endif

endinterface

// File: rtl/bus_prio_enc.sv
// Purely combinational priority encoder: highest set index wins, plus
// multi-drive detection (two or more bits set).
module bus_prio_enc #(
   parameter int NUM_SRC = 24,
   parameter int IDX_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] src_out,
   output logic [IDX_W-1:0]   sel,
   output logic               active,
   output logic               conflict
);

   logic [NUM_SRC-1:0] lowest_cleared;

   // Ascending scan so the last (highest) set bit overrides earlier ones.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_out[i]) sel = IDX_W'(i);
      end
   end

   // Clearing the lowest set bit leaves something only if popcount >= 2.
   always_comb begin
      lowest_cleared = src_out & (src_out - NUM_SRC'(1));
      active         = |src_out;
      conflict       = |lowest_cleared;
   end

endmodule

// File: rtl/bus_mux_hold.sv
// Datapath bus multiplexer with bus-hold, multi-drive conflict detection,
// sticky error flag and last-driver record.
// Optional macro BUS_CONFLICT_CNT_EN adds a saturating conflict counter.
module bus_mux_hold
   import cpu_bus_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int IDX_W   = $clog2(NUM_SRC)
`ifdef BUS_CONFLICT_CNT_EN
   ,
   parameter int CNT_W   = 8
`endif
) (
   input logic            clock,
   input logic            clear_n,
   bus_mux_hold_if.slave  bus
);

   logic [IDX_W-1:0] sel;
   logic             active;
   logic             conflict;
   logic [WIDTH-1:0] drive_word;
   logic [WIDTH-1:0] hold_q;
   logic             sticky_q;
   logic [IDX_W-1:0] last_q;

   bus_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_enc (
      .src_out  (bus.src_out),
      .sel      (sel),
      .active   (active),
      .conflict (conflict)
   );

   // Select the winning source word; zero-latency path to the bus.
   always_comb begin
      drive_word = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == IDX_W'(i)) drive_word = bus.src_data[i*WIDTH +: WIDTH];
      end
   end

   // Capture the driven value and its source so idle cycles replay it.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         hold_q <= '0;
         last_q <= '0;
      end else if (active) begin
         hold_q <= drive_word;
         last_q <= sel;
      end
   end

   // Sticky conflict flag; a conflict in the clearing cycle keeps it set.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n)           sticky_q <= 1'b0;
      else if (conflict)      sticky_q <= 1'b1;
      else if (bus.clr_err)   sticky_q <= 1'b0;
   end

`ifdef BUS_CONFLICT_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating conflict count; clear plus conflict restarts at one.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         cnt_q <= '0;
      end else if (conflict) begin
         if (bus.clr_err)      cnt_q <= CNT_W'(1);
         else if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end else if (bus.clr_err) begin
         cnt_q <= '0;
      end
   end

   assign bus.conflict_cnt = cnt_q;
`endif

   assign bus.bus_out         = active ? drive_word : hold_q;
   assign bus.bus_active      = active;
   assign bus.bus_sel         = sel;
   assign bus.conflict        = conflict;
   assign bus.conflict_sticky = sticky_q;
   assign bus.last_src        = last_q;

endmodule

// File: tb/tb_bus_mux_hold.sv
// Self-checking bench for bus_mux_hold: reset, a vector table of
// drive/idle/conflict cycles, then hand-written multi-cycle corner cases.
// Optional macro BUS_CONFLICT_CNT_EN enables the counter checks.
module tb_bus_mux_hold;
   import cpu_bus_pkg::*;

   localparam int WIDTH   = DEF_WIDTH;
   localparam int NUM_SRC = DEF_NUM_SRC;
   localparam int IDX_W   = $clog2(NUM_SRC);
`ifdef BUS_CONFLICT_CNT_EN
   localparam int CNT_W   = 2;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] bus;
      logic [IDX_W-1:0] sel;
      logic             act;
      logic             conf;
      logic             sticky;
      logic [IDX_W-1:0] last;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   typedef struct {
      logic [NUM_SRC-1:0] src_out;
      logic               clr;
      logic [WIDTH-1:0]   bus;
      logic [IDX_W-1:0]   sel;
      logic               act;
      logic               conf;
      logic               sticky;
      logic [IDX_W-1:0]   last;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic clear_n;
   always #5 clock = ~clock;

   bus_mux_hold_if #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
`ifdef BUS_CONFLICT_CNT_EN
      ,
      .CNT_W   (CNT_W)
`endif
   ) bus_if ();

   bus_mux_hold #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
`ifdef BUS_CONFLICT_CNT_EN
      ,
      .CNT_W   (CNT_W)
`endif
   ) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus_if)
   );

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   vec_t vecs[14];

   function automatic bus_word_t pat(input int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   task automatic cmp(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_word(input int i, input bus_word_t val);
      bus_if.src_data[i*WIDTH +: WIDTH] = val;
   endtask

   task automatic drive(input logic [NUM_SRC-1:0] so, input logic clr);
      @(negedge clock);
      bus_if.src_out = so;
      bus_if.clr_err = clr;
   endtask

   task automatic push_exp(input logic [WIDTH-1:0] b, input logic [IDX_W-1:0] s, input logic a,
                           input logic c, input logic st, input logic [IDX_W-1:0] l);
      exp_t e;
      e.bus = b; e.sel = s; e.act = a; e.conf = c; e.sticky = st; e.last = l;
      exp_q.push_back(EXP_W'(e));
   endtask

   task automatic sample(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got empty expected queue want an entry", tag);
         return;
      end
      e = exp_t'(exp_q.pop_front());
      cmp({tag, ".bus_out"},         bus_if.bus_out,                       e.bus);
      cmp({tag, ".bus_sel"},         WIDTH'(bus_if.bus_sel),               WIDTH'(e.sel));
      cmp({tag, ".bus_active"},      WIDTH'(bus_if.bus_active),            WIDTH'(e.act));
      cmp({tag, ".conflict"},        WIDTH'(bus_if.conflict),              WIDTH'(e.conf));
      cmp({tag, ".conflict_sticky"}, WIDTH'(bus_if.conflict_sticky),       WIDTH'(e.sticky));
      cmp({tag, ".last_src"},        WIDTH'(bus_if.last_src),              WIDTH'(e.last));
   endtask

   task automatic check_now(input string tag);
      #2;
      sample(tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      clear_n        = 1'b0;
      bus_if.src_out = '0;
      bus_if.clr_err = 1'b0;
      bus_if.src_data = '0;
      for (int i = 0; i < NUM_SRC; i++) set_word(i, pat(i));

      // Vectors: each row lists the outputs visible in that cycle, before its edge.
      vecs[0]  = '{24'h000000, 1'b0, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0};
      vecs[1]  = '{24'h000020, 1'b0, 32'hC0DE_0505, 5'd5,  1'b1, 1'b0, 1'b0, 5'd0};
      vecs[2]  = '{24'h000000, 1'b0, 32'hC0DE_0505, 5'd0,  1'b0, 1'b0, 1'b0, 5'd5};
      vecs[3]  = '{24'h000001, 1'b0, 32'hC0DE_0000, 5'd0,  1'b1, 1'b0, 1'b0, 5'd5};
      vecs[4]  = '{24'h000000, 1'b0, 32'hC0DE_0000, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0};
      vecs[5]  = '{24'h800001, 1'b0, 32'hC0DE_1717, 5'd23, 1'b1, 1'b1, 1'b0, 5'd0};
      vecs[6]  = '{24'h000000, 1'b0, 32'hC0DE_1717, 5'd0,  1'b0, 1'b0, 1'b1, 5'd23};
      vecs[7]  = '{24'h010000, 1'b1, 32'hC0DE_1010, 5'd16, 1'b1, 1'b0, 1'b1, 5'd23};
      vecs[8]  = '{24'h000000, 1'b0, 32'hC0DE_1010, 5'd0,  1'b0, 1'b0, 1'b0, 5'd16};
      vecs[9]  = '{24'h410080, 1'b1, 32'hC0DE_1616, 5'd22, 1'b1, 1'b1, 1'b0, 5'd16};
      vecs[10] = '{24'h000000, 1'b1, 32'hC0DE_1616, 5'd0,  1'b0, 1'b0, 1'b1, 5'd22};
      vecs[11] = '{24'h000000, 1'b0, 32'hC0DE_1616, 5'd0,  1'b0, 1'b0, 1'b0, 5'd22};
      vecs[12] = '{24'h800000, 1'b0, 32'hC0DE_1717, 5'd23, 1'b1, 1'b0, 1'b0, 5'd22};
      vecs[13] = '{24'h000000, 1'b0, 32'hC0DE_1717, 5'd0,  1'b0, 1'b0, 1'b0, 5'd23};

      // Reset state while clear_n is held low.
      @(negedge clock);
      @(negedge clock);
      push_exp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      check_now("reset");
`ifdef BUS_CONFLICT_CNT_EN
      cmp("reset.conflict_cnt", WIDTH'(bus_if.conflict_cnt), 32'd0);
`endif
      @(negedge clock);
      clear_n = 1'b1;

      // Table-driven vectors.
      for (int v = 0; v < 14; v++) begin
         drive(vecs[v].src_out, vecs[v].clr);
         push_exp(vecs[v].bus, vecs[v].sel, vecs[v].act, vecs[v].conf, vecs[v].sticky, vecs[v].last);
         check_now($sformatf("vec%0d", v));
      end

      // Single drive from PC, then hold.
      set_word(SRC_PC, 32'h0000_1234);
      drive(24'h100000, 1'b0);
      push_exp(32'h0000_1234, 5'd20, 1'b1, 1'b0, 1'b0, 5'd23);
      check_now("pc_drive");
      drive(24'h000000, 1'b0);
      push_exp(32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b0, 5'd20);
      check_now("pc_hold");

      // R3 and MDR conflict: MDR wins, sticky sets on the next edge.
      set_word(SRC_R3, 32'hAAAA_AAAA);
      set_word(SRC_MDR, 32'h5555_5555);
      drive(24'h200008, 1'b0);
      push_exp(32'h5555_5555, 5'd21, 1'b1, 1'b1, 1'b0, 5'd20);
      check_now("conflict");
      drive(24'h000000, 1'b0);
      push_exp(32'h5555_5555, 5'd0, 1'b0, 1'b0, 1'b1, 5'd21);
      check_now("conflict_after");

      // Clear racing a new conflict, then a plain clear.
      drive(24'h200008, 1'b1);
      push_exp(32'h5555_5555, 5'd21, 1'b1, 1'b1, 1'b1, 5'd21);
      check_now("clr_race");
      drive(24'h000000, 1'b1);
      push_exp(32'h5555_5555, 5'd0, 1'b0, 1'b0, 1'b1, 5'd21);
      check_now("clr_race_after");
      drive(24'h000000, 1'b0);
      push_exp(32'h5555_5555, 5'd0, 1'b0, 1'b0, 1'b0, 5'd21);
      check_now("clr_plain_after");

      // Async reset while holding DEADBEEF, no clock edge involved.
      set_word(SRC_R0, 32'hDEAD_BEEF);
      drive(24'h000001, 1'b0);
      push_exp(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b0, 5'd21);
      check_now("hold_load");
      drive(24'h000000, 1'b0);
      push_exp(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      check_now("hold_idle");
      #1 clear_n = 1'b0;
      push_exp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      #1 sample("async_reset");
      clear_n = 1'b1;

      // First active cycle after release behaves normally.
      set_word(SRC_R1, 32'h0BAD_F00D);
      drive(24'h000002, 1'b0);
      push_exp(32'h0BAD_F00D, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0);
      check_now("post_reset_drive");
      drive(24'h000000, 1'b0);
      push_exp(32'h0BAD_F00D, 5'd0, 1'b0, 1'b0, 1'b0, 5'd1);
      check_now("post_reset_hold");

`ifdef BUS_CONFLICT_CNT_EN
      // Counter saturates at 3 with a 2-bit width, then clears.
      begin
         logic [WIDTH-1:0] cnt_exp[5];
         cnt_exp[0] = 32'd1; cnt_exp[1] = 32'd2; cnt_exp[2] = 32'd3;
         cnt_exp[3] = 32'd3; cnt_exp[4] = 32'd3;
         for (int k = 0; k < 5; k++) begin
            drive(24'h200008, 1'b0);
            @(posedge clock);
            #1 cmp($sformatf("cnt%0d", k), WIDTH'(bus_if.conflict_cnt), cnt_exp[k]);
         end
         drive(24'h000000, 1'b1);
         @(posedge clock);
         #1 cmp("cnt_clear", WIDTH'(bus_if.conflict_cnt), 32'd0);
         drive(24'h000000, 1'b0);
      end
`endif

      // ---------------- report ----------------
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL leftover: got %0d queued want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
